// File: rtl/cfo_phase_accum.sv
// cfo_phase_accum
//   Carrier-frequency-offset phase accumulator. It is placed after the
//   short-preamble detector. On a detection pulse it latches the per-sample
//   phase offset, clamped to [-pi, +pi]. For every strobed sample after that,
//   it produces a wrapped, accumulated correction phase for the rotator.
//   Samples pass through with one cycle of latency, aligned to their phase.
//   Tracking stops on pkt_end or after max_track_len samples.
//
//   Optional macro CFO_LOCK_HOLD_EN: when defined, a detection pulse seen
//   while already tracking is ignored, so the first lock is held until
//   pkt_end or timeout.
module cfo_phase_accum #(
   parameter logic signed [16:0] PI_SCALED        = 17'sd1608,
   parameter logic signed [16:0] DOUBLE_PI_SCALED = 17'sd3217
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic [31:0] sample_in,
   input  logic        sample_in_strobe,
   input  logic        short_preamble_detected,
   input  logic [15:0] phase_offset,
   input  logic        pkt_end,
   input  logic [31:0] max_track_len,
   output logic [31:0] sample_out,
   output logic        sample_out_strobe,
   output logic [15:0] phase_corr,
   output logic        locked
);

   localparam logic signed [16:0] NEG_PI_SCALED = -PI_SCALED;

`ifdef CFO_LOCK_HOLD_EN
   localparam logic REDETECT_EN = 1'b0;
`else
   localparam logic REDETECT_EN = 1'b1;
`endif

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      TRACK = 1'b1
   } state_t;

   state_t             state_r, state_s;
   logic signed [15:0] acc_r, acc_s;
   logic signed [15:0] offset_r, offset_s;
   logic [31:0]        track_cnt_r, track_cnt_s;
   logic [31:0]        sample_out_s;
   logic               strobe_s;
   logic [15:0]        phase_corr_s;
   logic               locked_s;
   logic [31:0]        last_idx_s;
   logic               timeout_s;
   logic               restart_s;
   logic signed [15:0] wrapped_s;
   logic signed [15:0] clamped_s;
   logic [31:0]        cnt_inc_s;

   // Limit a signed offset to [-pi, +pi].
   function automatic logic signed [15:0] clamp_offset(input logic signed [15:0] off);
      logic signed [16:0] ext;
      ext = {off[15], off};
      if (ext > PI_SCALED) begin
         return PI_SCALED[15:0];
      end else if (ext < NEG_PI_SCALED) begin
         return NEG_PI_SCALED[15:0];
      end else begin
         return off;
      end
   endfunction

   // Add two in-range phases at 17 bits and fold the result back into [-pi, +pi].
   function automatic logic signed [15:0] wrap_add(input logic signed [15:0] a,
                                                   input logic signed [15:0] b);
      logic signed [16:0] sum;
      logic signed [16:0] res;
      sum = {a[15], a} + {b[15], b};
      if (sum > PI_SCALED) begin
         res = sum - DOUBLE_PI_SCALED;
      end else if (sum < NEG_PI_SCALED) begin
         res = sum + DOUBLE_PI_SCALED;
      end else begin
         res = sum;
      end
      return res[15:0];
   endfunction

   // Derived helpers: timeout index (a limit of 0 behaves as 1), saturating count, next phase.
   always_comb begin
      if (max_track_len == 32'd0) begin
         last_idx_s = 32'd0;
      end else begin
         last_idx_s = max_track_len - 32'd1;
      end
      timeout_s = (track_cnt_r == last_idx_s);
      if (track_cnt_r == 32'hFFFF_FFFF) begin
         cnt_inc_s = track_cnt_r;
      end else begin
         cnt_inc_s = track_cnt_r + 32'd1;
      end
      wrapped_s = wrap_add(acc_r, offset_r);
      clamped_s = clamp_offset(phase_offset);
      restart_s = short_preamble_detected & ~pkt_end &
                  ((state_r == IDLE) | REDETECT_EN);
   end

   // Next-state, accumulator and output-register values; priority pkt_end > detect > timeout > accumulate.
   always_comb begin
      state_s      = state_r;
      acc_s        = acc_r;
      offset_s     = offset_r;
      track_cnt_s  = track_cnt_r;
      locked_s     = locked;
      sample_out_s = sample_out;
      strobe_s     = 1'b0;
      phase_corr_s = phase_corr;

      if (sample_in_strobe) begin
         sample_out_s = sample_in;
         strobe_s     = 1'b1;
         if ((state_r == TRACK) && !restart_s) begin
            phase_corr_s = acc_r;
         end else begin
            phase_corr_s = 16'sd0;
         end
      end else begin
         strobe_s = 1'b0;
      end

      case (state_r)
         IDLE: begin
            acc_s = 16'sd0;
            if (restart_s) begin
               state_s     = TRACK;
               offset_s    = clamped_s;
               track_cnt_s = 32'd0;
               locked_s    = 1'b1;
            end else begin
               state_s  = IDLE;
               locked_s = 1'b0;
            end
         end
         TRACK: begin
            if (pkt_end) begin
               state_s     = IDLE;
               acc_s       = 16'sd0;
               track_cnt_s = 32'd0;
               locked_s    = 1'b0;
            end else if (restart_s) begin
               offset_s    = clamped_s;
               acc_s       = 16'sd0;
               track_cnt_s = 32'd0;
               locked_s    = 1'b1;
            end else if (sample_in_strobe) begin
               if (timeout_s) begin
                  state_s     = IDLE;
                  acc_s       = 16'sd0;
                  track_cnt_s = 32'd0;
                  locked_s    = 1'b0;
               end else begin
                  acc_s       = wrapped_s;
                  track_cnt_s = cnt_inc_s;
               end
            end else begin
               state_s = TRACK;
            end
         end
         default: begin
            state_s     = IDLE;
            acc_s       = 16'sd0;
            track_cnt_s = 32'd0;
            locked_s    = 1'b0;
         end
      endcase
   end

   // State and output registers; enable low freezes everything and only drops the strobe.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r           <= IDLE;
         acc_r             <= 16'sd0;
         offset_r          <= 16'sd0;
         track_cnt_r       <= 32'd0;
         sample_out        <= 32'd0;
         sample_out_strobe <= 1'b0;
         phase_corr        <= 16'd0;
         locked            <= 1'b0;
      end else if (enable) begin
         state_r           <= state_s;
         acc_r             <= acc_s;
         offset_r          <= offset_s;
         track_cnt_r       <= track_cnt_s;
         sample_out        <= sample_out_s;
         sample_out_strobe <= strobe_s;
         phase_corr        <= phase_corr_s;
         locked            <= locked_s;
      end else begin
         sample_out_strobe <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cfo_phase_accum.sv
// Directed testbench for cfo_phase_accum. The expected phase sequences are
// hand-computed from the wrap rule (pi = 1608, 2*pi = 3217).
module tb_cfo_phase_accum;

   logic        clock;
   logic        reset;
   logic        enable;
   logic [31:0] sample_in;
   logic        sample_in_strobe;
   logic        short_preamble_detected;
   logic [15:0] phase_offset;
   logic        pkt_end;
   logic [31:0] max_track_len;
   logic [31:0] sample_out;
   logic        sample_out_strobe;
   logic [15:0] phase_corr;
   logic        locked;

   int n_cmp;
   int n_err;

   cfo_phase_accum dut (
      .clock                   (clock),
      .reset                   (reset),
      .enable                  (enable),
      .sample_in               (sample_in),
      .sample_in_strobe        (sample_in_strobe),
      .short_preamble_detected (short_preamble_detected),
      .phase_offset            (phase_offset),
      .pkt_end                 (pkt_end),
      .max_track_len           (max_track_len),
      .sample_out              (sample_out),
      .sample_out_strobe       (sample_out_strobe),
      .phase_corr              (phase_corr),
      .locked                  (locked)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (obs !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, then wait until just after the edge.
   task automatic step(input logic strb, input logic det, input int off,
                       input logic pe, input logic [31:0] data);
      logic [31:0] off32;
      off32 = off;
      @(negedge clock);
      sample_in_strobe        = strb;
      short_preamble_detected = det;
      phase_offset            = off32[15:0];
      pkt_end                 = pe;
      sample_in               = data;
      @(posedge clock);
      #1;
   endtask

   task automatic samp_chk(input string tag, input logic [31:0] data,
                           input int exp_ph, input logic exp_lk);
      logic [31:0] e32;
      e32 = exp_ph;
      step(1'b1, 1'b0, 0, 1'b0, data);
      check_val({tag, ".data"}, sample_out, data);
      check_val({tag, ".stb"}, {31'd0, sample_out_strobe}, 32'd1);
      check_val({tag, ".ph"}, {16'd0, phase_corr}, {16'd0, e32[15:0]});
      check_val({tag, ".lk"}, {31'd0, locked}, {31'd0, exp_lk});
   endtask

   task automatic detect(input string tag, input int off);
      step(1'b0, 1'b1, off, 1'b0, 32'd0);
      check_val({tag, ".det_lk"}, {31'd0, locked}, 32'd1);
      check_val({tag, ".det_stb"}, {31'd0, sample_out_strobe}, 32'd0);
   endtask

   task automatic end_pkt(input string tag);
      step(1'b0, 1'b0, 0, 1'b1, 32'd0);
      check_val({tag, ".end_lk"}, {31'd0, locked}, 32'd0);
   endtask

   int ph100 [5]  = '{0, 100, 200, 300, 400};
   int ph1000 [5] = '{0, 1000, -1217, -217, 783};
   int phneg [4]  = '{0, -1608, 1, -1607};
   int ph_re [3];
   int ph_after_en;

   initial begin
      n_cmp = 0;
      n_err = 0;
`ifdef CFO_LOCK_HOLD_EN
      ph_re       = '{40, 50, 60};
      ph_after_en = 70;
`else
      ph_re       = '{0, 50, 100};
      ph_after_en = 150;
`endif
      reset = 1'b1;
      enable = 1'b1;
      sample_in = 32'd0;
      sample_in_strobe = 1'b0;
      short_preamble_detected = 1'b0;
      phase_offset = 16'd0;
      pkt_end = 1'b0;
      max_track_len = 32'd1000;
      repeat (2) @(posedge clock);
      #1;
      check_val("rst.data", sample_out, 32'd0);
      check_val("rst.stb", {31'd0, sample_out_strobe}, 32'd0);
      check_val("rst.ph", {16'd0, phase_corr}, 32'd0);
      check_val("rst.lk", {31'd0, locked}, 32'd0);
      @(negedge clock);
      reset = 1'b0;

      // IDLE pass-through
      for (int i = 0; i < 5; i++) samp_chk("idle", 32'hA000_0000 + 32'(i * 7), 0, 1'b0);

      // Offset 100
      detect("o100", 100);
      for (int i = 0; i < 5; i++) samp_chk("o100", 32'h1234_0000 + 32'(i), ph100[i], 1'b1);
      end_pkt("o100");
      samp_chk("o100.post", 32'h5555_AAAA, 0, 1'b0);

      // Offset 1000 with wrap
      detect("o1000", 1000);
      for (int i = 0; i < 5; i++) samp_chk("o1000", 32'hBEEF_0000 + 32'(i), ph1000[i], 1'b1);
      end_pkt("o1000");

      // Clamped negative offset
      detect("oneg", -2000);
      for (int i = 0; i < 4; i++) samp_chk("oneg", 32'hC0DE_0000 + 32'(i), phneg[i], 1'b1);
      end_pkt("oneg");

      // Timeout after 3 samples
      max_track_len = 32'd3;
      detect("tmo", 10);
      samp_chk("tmo0", 32'h0000_0001, 0, 1'b1);
      samp_chk("tmo1", 32'h0000_0002, 10, 1'b1);
      samp_chk("tmo2", 32'h0000_0003, 20, 1'b0);
      samp_chk("tmo3", 32'h0000_0004, 0, 1'b0);

      // pkt_end mid-stream
      max_track_len = 32'd1000;
      detect("pe", 10);
      samp_chk("pe0", 32'h0000_0011, 0, 1'b1);
      samp_chk("pe1", 32'h0000_0012, 10, 1'b1);
      end_pkt("pe");
      samp_chk("pe2", 32'h0000_0013, 0, 1'b0);

      // Second detection while tracking, then enable-low hold
      detect("re", 10);
      for (int i = 0; i < 4; i++) samp_chk("re.a", 32'h0000_0020 + 32'(i), i * 10, 1'b1);
      detect("re2", 50);
      for (int i = 0; i < 3; i++) samp_chk("re.b", 32'h0000_0030 + 32'(i), ph_re[i], 1'b1);
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 0, 1'b0, 32'hDEAD_0000 + 32'(i));
         check_val("en.stb", {31'd0, sample_out_strobe}, 32'd0);
      end
      enable = 1'b1;
      samp_chk("en.after", 32'h0000_0040, ph_after_en, 1'b1);
      end_pkt("en");

      // Detection with a same-cycle sample: phase 0, no accumulation
      step(1'b1, 1'b1, 100, 1'b0, 32'h7777_0000);
      check_val("dsame.stb", {31'd0, sample_out_strobe}, 32'd1);
      check_val("dsame.ph", {16'd0, phase_corr}, 32'd0);
      check_val("dsame.lk", {31'd0, locked}, 32'd1);
      samp_chk("dsame0", 32'h7777_0001, 0, 1'b1);
      samp_chk("dsame1", 32'h7777_0002, 100, 1'b1);
      end_pkt("dsame");

      // max_track_len = 0 behaves as 1
      max_track_len = 32'd0;
      detect("m0", 10);
      samp_chk("m0.0", 32'h0000_0050, 0, 1'b0);
      samp_chk("m0.1", 32'h0000_0051, 0, 1'b0);
      max_track_len = 32'd1000;

      // pkt_end together with detection stays IDLE
      step(1'b0, 1'b1, 100, 1'b1, 32'd0);
      check_val("pe_det.lk", {31'd0, locked}, 32'd0);
      samp_chk("pe_det.s", 32'h0000_0060, 0, 1'b0);

      // Reset mid-TRACK: no strobe, reset values
      detect("rmid", 100);
      samp_chk("rmid0", 32'h0000_0070, 0, 1'b1);
      samp_chk("rmid1", 32'h0000_0071, 100, 1'b1);
      reset = 1'b1;
      step(1'b1, 1'b0, 0, 1'b0, 32'h0000_0072);
      check_val("rmid.stb", {31'd0, sample_out_strobe}, 32'd0);
      check_val("rmid.ph", {16'd0, phase_corr}, 32'd0);
      check_val("rmid.lk", {31'd0, locked}, 32'd0);
      check_val("rmid.data", sample_out, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      samp_chk("rmid.post", 32'h0000_0073, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
